// File: rtl/cpu_uart_tx_if.sv
// cpu_uart_tx_if: 6502 system-bus slice seen by the memory-mapped UART.
//   AB  : CPU address bus (16 bits)
//   DO  : CPU write data (8 bits)
//   WE  : CPU write strobe, a write commits at the rising edge where WE=1
//   DI  : registered read data returned by the peripheral
//   sel : registered flag, DI belongs to this peripheral this cycle
// The master modport is the CPU side. The slave modport is the peripheral side.
interface cpu_uart_tx_if;
  logic [15:0] AB;
  logic [7:0]  DO;
  logic        WE;
  logic [7:0]  DI;
  logic        sel;

  modport master (output AB, output DO, output WE, input DI, input sel);
  modport slave  (input AB, input DO, input WE, output DI, output sel);
endinterface

// File: rtl/cpu_uart_tx.sv
// cpu_uart_tx: memory-mapped 8-N-1 UART transmitter with a small TX FIFO.
//   clk      : system clock shared with the CPU core
//   reset_n  : asynchronous active-low reset
//   bus      : CPU bus slave (AB/DO/WE in, registered DI/sel out)
//   txd      : serial output, idle high
//   irq      : registered level interrupt, irq_en & fifo_empty & idle
// Register window at BASE_ADDR:
//   +0 DATA   (W: push byte, R: 0)
//   +1 STATUS (R: {0000, overflow, busy, empty, full}; W: clear overflow)
//   +2 CTRL   (bit0 irq_en)
//   +3 unused (R: 0)
module cpu_uart_tx #(
  parameter logic [15:0] BASE_ADDR    = 16'hD000,
  parameter int          CLKS_PER_BIT = 434,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  cpu_uart_tx_if.slave    bus,
  output logic            txd,
  output logic            irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int KW = $clog2(CLKS_PER_BIT);
  localparam logic [KW-1:0] CLK_LAST = KW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [KW-1:0]   r_clkcnt;
  logic [KW-1:0]   w_clkcnt_nxt;
  logic [2:0]      r_bitcnt;
  logic [2:0]      w_bitcnt_nxt;
  logic [7:0]      r_shift;
  logic [7:0]      w_shift_nxt;
  logic            r_txd;
  logic            w_txd_nxt;

  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic            r_overflow;
  logic            r_irq_en;
  logic [7:0]      r_di;
  logic            r_sel;
  logic            r_irq;

  logic            w_hit;
  logic [1:0]      w_off;
  logic            w_wr;
  logic            w_push_req;
  logic            w_push;
  logic            w_drop;
  logic            w_pop;
  logic            w_full;
  logic            w_empty;
  logic            w_busy;
  logic            w_bit_end;
  logic [7:0]      w_head;
  logic [7:0]      w_status;
  logic [7:0]      w_rdata;

  assign w_hit      = (bus.AB[15:2] == BASE_ADDR[15:2]);
  assign w_off      = bus.AB[1:0];
  assign w_wr       = bus.WE & w_hit;
  assign w_push_req = w_wr & (w_off == 2'd0);
  assign w_full     = (r_count == CNT_FULL);
  assign w_empty    = (r_count == {CW{1'b0}});
  // A same-cycle pop frees the slot, so a push into a full FIFO is only dropped without one.
  assign w_push     = w_push_req & (~w_full | w_pop);
  assign w_drop     = w_push_req & w_full & ~w_pop;
  assign w_busy     = (r_state != S_IDLE);
  assign w_bit_end  = (r_clkcnt == CLK_LAST);
  assign w_head     = r_mem[r_rptr];
  assign w_status   = {4'b0000, r_overflow, w_busy, w_empty, w_full};

  assign txd     = r_txd;
  assign irq     = r_irq;
  assign bus.DI  = r_di;
  assign bus.sel = r_sel;

  // FIFO storage; contents need no reset because the count gates every read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= bus.DO;
    end
  end

  // FIFO pointers and occupancy count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= {AW{1'b0}};
      r_rptr  <= {AW{1'b0}};
      r_count <= {CW{1'b0}};
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // TX FSM next-state, counters, shifter and next serial level.
  always_comb begin
    w_state_nxt  = r_state;
    w_clkcnt_nxt = r_clkcnt;
    w_bitcnt_nxt = r_bitcnt;
    w_shift_nxt  = r_shift;
    w_pop        = 1'b0;
    w_txd_nxt    = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_clkcnt_nxt = {KW{1'b0}};
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_head;
          w_state_nxt = S_START;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_clkcnt_nxt = {KW{1'b0}};
          w_bitcnt_nxt = 3'd0;
          w_state_nxt  = S_DATA;
        end else begin
          w_clkcnt_nxt = r_clkcnt + KW'(1);
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_clkcnt_nxt = {KW{1'b0}};
          w_shift_nxt  = {1'b0, r_shift[7:1]};
          if (r_bitcnt == 3'd7) begin
            w_bitcnt_nxt = 3'd0;
            w_state_nxt  = S_STOP;
          end else begin
            w_bitcnt_nxt = r_bitcnt + 3'd1;
          end
        end else begin
          w_clkcnt_nxt = r_clkcnt + KW'(1);
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          w_clkcnt_nxt = {KW{1'b0}};
          // Chain straight into the next start bit when more data is queued.
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_shift_nxt = w_head;
            w_state_nxt = S_START;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_clkcnt_nxt = r_clkcnt + KW'(1);
        end
      end
      default: begin
        w_state_nxt  = S_IDLE;
        w_clkcnt_nxt = {KW{1'b0}};
        w_bitcnt_nxt = 3'd0;
      end
    endcase
    // txd is registered from the next state so it changes on the same edge as the state.
    case (w_state_nxt)
      S_START: w_txd_nxt = 1'b0;
      S_DATA:  w_txd_nxt = w_shift_nxt[0];
      default: w_txd_nxt = 1'b1;
    endcase
  end

  // TX FSM state register; reset forces txd high without waiting for a clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_clkcnt <= {KW{1'b0}};
      r_bitcnt <= 3'd0;
      r_shift  <= 8'h00;
      r_txd    <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      r_clkcnt <= w_clkcnt_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      r_shift  <= w_shift_nxt;
      r_txd    <= w_txd_nxt;
    end
  end

  // Read data mux; reads have no side effects.
  always_comb begin
    w_rdata = 8'h00;
    if (w_hit) begin
      case (w_off)
        2'd1:    w_rdata = w_status;
        2'd2:    w_rdata = {7'b0000000, r_irq_en};
        default: w_rdata = 8'h00;
      endcase
    end else begin
      w_rdata = 8'h00;
    end
  end

  // Control and status registers, registered read port, and interrupt.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow <= 1'b0;
      r_irq_en   <= 1'b0;
      r_di       <= 8'h00;
      r_sel      <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (w_wr && (w_off == 2'd1)) begin
        r_overflow <= 1'b0;
      end
      if (w_wr && (w_off == 2'd2)) begin
        r_irq_en <= bus.DO[0];
      end
      r_di  <= w_rdata;
      r_sel <= w_hit;
      r_irq <= r_irq_en & w_empty & ~w_busy;
    end
  end
endmodule

// File: tb/tb_cpu_uart_tx.sv
// tb_cpu_uart_tx: self-checking bench for cpu_uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=4).
// A queue-based model predicts txd/DI/sel/irq every cycle. A txd frame is expanded
// into a queue of per-cycle line levels when a byte leaves the FIFO.
module tb_cpu_uart_tx;
  localparam int          CPB   = 4;
  localparam int          DEPTH = 4;
  localparam logic [15:0] BASE  = 16'hD000;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic txd;
  logic irq;

  cpu_uart_tx_if bus();

  cpu_uart_tx #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .txd     (txd),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- behavioural model ----------------
  logic [7:0] m_q[$];
  bit         m_txq[$];
  bit         m_busy  = 1'b0;
  bit         m_ovf   = 1'b0;
  bit         m_irqen = 1'b0;
  logic [7:0] m_di    = 8'h00;
  bit         m_sel   = 1'b0;
  bit         m_irq   = 1'b0;
  bit         m_txd   = 1'b1;

  task automatic model_reset();
    m_q.delete();
    m_txq.delete();
    m_busy = 1'b0; m_ovf = 1'b0; m_irqen = 1'b0;
    m_di = 8'h00; m_sel = 1'b0; m_irq = 1'b0; m_txd = 1'b1;
  endtask

  task automatic model_step();
    logic       hit;
    logic [1:0] off;
    logic [7:0] status;
    logic [9:0] frame;
    logic [7:0] b;
    bit         empty, full, pop;
    hit    = (bus.AB[15:2] == BASE[15:2]);
    off    = bus.AB[1:0];
    empty  = (m_q.size() == 0);
    full   = (m_q.size() == DEPTH);
    status = {4'h0, m_ovf, m_busy, empty, full};
    m_sel  = hit;
    m_di   = 8'h00;
    if (hit && off == 2'd1) m_di = status;
    if (hit && off == 2'd2) m_di = {7'h00, m_irqen};
    m_irq  = m_irqen && empty && !m_busy;
    // A byte leaves the FIFO whenever no line levels remain queued for the current frame.
    pop = !empty && (m_txq.size() == 0);
    if (pop) begin
      b = m_q.pop_front();
      frame = {1'b1, b, 1'b0};
      for (int k = 0; k < 10; k++)
        for (int c = 0; c < CPB; c++) m_txq.push_back(frame[k]);
    end
    if (bus.WE && hit) begin
      case (off)
        2'd0: if (!full || pop) m_q.push_back(bus.DO); else m_ovf = 1'b1;
        2'd1: m_ovf = 1'b0;
        2'd2: m_irqen = bus.DO[0];
        default: ;
      endcase
    end
    if (m_txq.size() > 0) begin
      m_txd  = m_txq.pop_front();
      m_busy = 1'b1;
    end else begin
      m_txd  = 1'b1;
      m_busy = 1'b0;
    end
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) model_reset();
    else          model_step();
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("txd", {31'd0, txd},     {31'd0, m_txd});
    check("DI",  {24'd0, bus.DI},  {24'd0, m_di});
    check("sel", {31'd0, bus.sel}, {31'd0, m_sel});
    check("irq", {31'd0, irq},     {31'd0, m_irq});
  end

  // ---------------- stimulus helpers ----------------
  task automatic bus_cycle(input logic [15:0] a, input logic [7:0] d, input logic we);
    @(posedge clk);
    #1;
    bus.AB = a; bus.DO = d; bus.WE = we;
  endtask

  task automatic expect_read(input logic [15:0] a, input logic [7:0] exp, input string name);
    bus_cycle(a, 8'h00, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check(name, {24'd0, bus.DI}, {24'd0, exp});
    check({name, "_sel"}, {31'd0, bus.sel}, 32'd1);
  endtask

  logic [9:0] f1;
  logic [9:0] f2;
  int         lowcnt;
  int         r;

  initial begin
    bus.AB = 16'h0000; bus.DO = 8'h00; bus.WE = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_txd", {31'd0, txd}, 32'd1);
    check("rst_sel", {31'd0, bus.sel}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    expect_read(BASE + 16'd1, 8'h02, "rst_status");

    // Single byte A5: start bit from E+1 then LSB-first data and stop
    bus_cycle(BASE, 8'hA5, 1'b1);
    bus_cycle(16'h0000, 8'h00, 1'b0);
    @(posedge clk);
    f1 = {1'b1, 8'hA5, 1'b0};
    for (int b = 0; b < 10; b++) begin
      @(negedge clk);
      check("a5_bit", {31'd0, txd}, {31'd0, f1[b]});
      repeat (CPB) @(posedge clk);
    end
    repeat (5) @(posedge clk);

    // Mid-frame status: busy with an empty FIFO, then idle and empty
    bus_cycle(BASE, 8'h3C, 1'b1);
    bus_cycle(16'h0000, 8'h00, 1'b0);
    repeat (8) @(posedge clk);
    expect_read(BASE + 16'd1, 8'h06, "midframe_status");
    repeat (45) @(posedge clk);
    expect_read(BASE + 16'd1, 8'h02, "after_status");

    // Back-to-back frames with no gap, then a high line
    bus_cycle(BASE, 8'h55, 1'b1);
    bus_cycle(BASE, 8'h0F, 1'b1);
    bus_cycle(16'h0000, 8'h00, 1'b0);
    f1 = {1'b1, 8'h55, 1'b0};
    f2 = {1'b1, 8'h0F, 1'b0};
    for (int k = 0; k < 84; k++) begin
      @(negedge clk);
      if (k < 40)      check("b2b_txd", {31'd0, txd}, {31'd0, f1[k / CPB]});
      else if (k < 80) check("b2b_txd", {31'd0, txd}, {31'd0, f2[(k - 40) / CPB]});
      else             check("b2b_txd", {31'd0, txd}, 32'd1);
    end
    repeat (10) @(posedge clk);

    // Overflow: one in flight, four buffered, sixth dropped
    for (int i = 0; i < 6; i++) bus_cycle(BASE, 8'h10 + 8'(i), 1'b1);
    expect_read(BASE + 16'd1, 8'h0D, "ovf_status");
    bus_cycle(BASE + 16'd1, 8'h00, 1'b1);
    expect_read(BASE + 16'd1, 8'h05, "ovf_clear");
    repeat (230) @(posedge clk);
    expect_read(BASE + 16'd1, 8'h02, "ovf_drained");

    // IRQ enable, drop while sending, return when idle
    bus_cycle(BASE + 16'd2, 8'h01, 1'b1);
    bus_cycle(16'h0000, 8'h00, 1'b0);
    @(negedge clk);
    check("irq_lag", {31'd0, irq}, 32'd0);
    @(negedge clk);
    check("irq_on", {31'd0, irq}, 32'd1);
    bus_cycle(BASE, 8'hC3, 1'b1);
    bus_cycle(16'h0000, 8'h00, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("irq_busy", {31'd0, irq}, 32'd0);
    expect_read(BASE + 16'd2, 8'h01, "ctrl_read");
    repeat (45) @(negedge clk);
    check("irq_back", {31'd0, irq}, 32'd1);
    bus_cycle(BASE + 16'd2, 8'h00, 1'b1);

    // Asynchronous reset in the middle of a data bit with a byte still queued
    bus_cycle(BASE, 8'h81, 1'b1);
    bus_cycle(BASE, 8'h7E, 1'b1);
    bus_cycle(16'h0000, 8'h00, 1'b0);
    repeat (12) @(posedge clk);
    #1;
    check("pre_rst_txd", {31'd0, txd}, 32'd0);
    reset_n = 1'b0;
    #1;
    check("async_rst_txd", {31'd0, txd}, 32'd1);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    expect_read(BASE + 16'd1, 8'h02, "post_rst_status");
    lowcnt = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (txd == 1'b0) lowcnt++;
    end
    check("no_frame", lowcnt, 32'd0);

    // Randomised bus traffic against the model
    for (int i = 0; i < 2500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 10)      bus_cycle(BASE,          8'($urandom), 1'b1);
      else if (r < 12) bus_cycle(BASE + 16'd1,  8'($urandom), 1'b1);
      else if (r < 16) bus_cycle(BASE + 16'd2,  8'($urandom), 1'b1);
      else if (r < 18) bus_cycle(BASE + 16'd3,  8'($urandom), 1'b1);
      else if (r < 32) bus_cycle(BASE + 16'($urandom_range(0, 3)), 8'($urandom), 1'b0);
      else if (r < 36) bus_cycle(16'($urandom), 8'($urandom), 1'($urandom));
      else             bus_cycle(16'h0000, 8'($urandom), 1'b0);
    end
    bus_cycle(16'h0000, 8'h00, 1'b0);
    repeat (300) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
